maze_game_ctrl: RTL
===================

MAZE_GAME_CTRL -- requirements
Module: maze_game_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEVELS, 4, levels per game (2..8).
REQ-002 SHALL have parameter BOUNCE_FRAMES, 8, frames a bounce request is held (1..255).
REQ-003 SHALL have parameter DONE_FRAMES, 60, frames of level-complete pause (1..255).
REQ-004 SHALL have parameter LEVEL_TIME, 1800, frames allowed per level when the timer is enabled (1..4095).
REQ-005 SHALL have ports Clk in 1, system clock; Reset in 1, synchronous active-high reset.
REQ-006 SHALL have ports frame_clk in 1, vertical-sync frame clock; keycode in 8, current key; wall_hit in 1, sprite overlaps maze wall.
REQ-007 SHALL have ports L, R, U, D in 1 each, last sprite move direction; my_end in 1, sprite in exit zone.
REQ-008 SHALL have outputs spr_on 1, sprite motion enable; inc 1, sprite position reload pulse.
REQ-009 SHALL have outputs bnceL, bnceR, bnceU, bnceD 1 each, bounce requests; level 3, current level index.
REQ-010 SHALL have outputs state 3, FSM state code; time_left 12, frames remaining in level.

Function
REQ-011 SHALL derive frame tick as registered rising edge of frame_clk: one Clk-cycle pulse per frame; all frame-based counts advance only on tick.
REQ-012 SHALL implement states TITLE=0, PLAY=1, BOUNCE=2, LVL_DONE=3, WIN=4, OVER=5; all outputs registered, visible one Clk after the deciding edge.
REQ-013 TITLE: spr_on=0; keycode 8'h28 (Enter) -> PLAY, level=0, inc=1 for exactly one Clk.
REQ-014 PLAY: spr_on=1; on tick with my_end=1 -> LVL_DONE; else on tick with wall_hit=1 and any of L/R/U/D set -> BOUNCE.
REQ-015 Entering BOUNCE SHALL latch the opposite direction (L->bnceR, R->bnceL, U->bnceD, D->bnceU; priority L>R>U>D if several set) and load bounce counter with BOUNCE_FRAMES.
REQ-016 BOUNCE: spr_on=1, latched bnce* held high; counter decrements per tick; at 0 -> PLAY with all bnce* cleared same cycle.
REQ-017 my_end on tick in BOUNCE SHALL go to LVL_DONE immediately, clearing bnce*; my_end beats wall_hit when simultaneous.
REQ-018 LVL_DONE: spr_on=0, bnce*=0; after DONE_FRAMES ticks -> WIN if level==NUM_LEVELS-1, else level+1, inc pulse, -> PLAY.
REQ-019 WIN and OVER: spr_on=0; Enter -> TITLE; level holds until next game start.
REQ-020 inc SHALL never be high for more than one consecutive Clk and never outside a transition into PLAY.
REQ-021 Enter held across TITLE->PLAY SHALL NOT retrigger; Enter in PLAY/BOUNCE/LVL_DONE ignored.
REQ-022 Invalid state codes SHALL recover to TITLE on next Clk.

Reset
REQ-023 Reset SHALL force state=TITLE, spr_on=0, inc=0, bnce*=0, level=0, time_left=0, all counters 0, edge detector cleared.
REQ-024 Reset mid-BOUNCE or mid-LVL_DONE SHALL abort with no inc pulse and no bnce* pulse in following cycle.

Configuration
REQ-025 With LEVEL_TIMER_EN defined: time_left loads LEVEL_TIME on every inc pulse, decrements per tick in PLAY/BOUNCE, saturates at 0; reaching 0 in PLAY/BOUNCE -> OVER (my_end on same tick wins -> LVL_DONE).
REQ-026 Without LEVEL_TIMER_EN: time_left tied 0, OVER unreachable, timer logic absent.

Structure
REQ-027 Package maze_pkg SHALL hold state enum, KEY_ENTER=8'h28, and direction constants.
REQ-028 Sub-module frame_tick (edge detector + tick output) SHALL be instantiated once.

Verification
REQ-029 Reset, Enter, 3 frames -> inc single pulse, state=1, spr_on=1, level=0.
REQ-030 PLAY with R=1, wall_hit on tick -> bnceL=1 for exactly 8 ticks, then state=1, bnceL=0.
REQ-031 my_end and wall_hit same tick -> state=3, no bnce*; after 60 ticks inc pulse, level=1.
REQ-032 Complete level 3 (NUM_LEVELS=4) -> after 60 ticks state=4, no inc; Enter -> state=0.
REQ-033 LEVEL_TIMER_EN, LEVEL_TIME=10: no my_end for 10 ticks -> time_left=0, state=5, spr_on=0.
REQ-034 Reset asserted at bounce tick 4 -> next cycle state=0, all bnce*=0, level=0.

Source files
------------

// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze game controller:
//   state_t      - controller state encoding (also exported on the state port)
//   KEY_ENTER    - keycode that starts/restarts a game
//   DIR_*        - bit positions of the bounce vector {bnceL, bnceR, bnceU, bnceD}
//   bounce_of()  - maps the last move direction to the opposite bounce request
// ---------------------------------------------------------------------------
package maze_pkg;

    typedef enum logic [2:0] {
        ST_TITLE    = 3'd0,
        ST_PLAY     = 3'd1,
        ST_BOUNCE   = 3'd2,
        ST_LVL_DONE = 3'd3,
        ST_WIN      = 3'd4,
        ST_OVER     = 3'd5
    } state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Bit positions inside the 4-bit bounce vector.
    localparam int DIR_L = 3;
    localparam int DIR_R = 2;
    localparam int DIR_U = 1;
    localparam int DIR_D = 0;

    // The sprite is pushed back the way it came; if several directions are
    // flagged, L wins over R over U over D.
    function automatic logic [3:0] bounce_of(input logic l, input logic r,
                                             input logic u, input logic d);
        logic [3:0] b;
        b = '0;
        if (l)      b[DIR_R] = 1'b1;
        else if (r) b[DIR_L] = 1'b1;
        else if (u) b[DIR_D] = 1'b1;
        else if (d) b[DIR_U] = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/frame_tick.sv
// ---------------------------------------------------------------------------
// frame_tick
// Converts the slow vertical-sync frame clock into a one-Clk-wide tick on
// each rising edge of frame_clk. The tick is registered.
// Ports:
//   Clk       in  system clock
//   Reset     in  synchronous active-high reset (clears edge history)
//   frame_clk in  vertical-sync frame clock (sampled as data)
//   tick      out one-cycle pulse per frame
// ---------------------------------------------------------------------------
module frame_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic frame_clk_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            tick        <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
            tick        <= frame_clk & ~frame_clk_q;
        end
    end

endmodule

// File: rtl/maze_game_ctrl.sv
// ---------------------------------------------------------------------------
// maze_game_ctrl
// Game-flow controller for a maze game: title screen, per-level play with
// wall bounces, level-complete pause, win screen and (optionally) a per-level
// time limit leading to game over.
//
// Optional feature: define LEVEL_TIMER_EN to enable the per-level timer.
// Without it time_left is tied to 0 and the OVER state cannot be reached.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   frame_clk             vertical-sync clock; its rising edges are frames
//   keycode[7:0]          current key (Enter = KEY_ENTER)
//   wall_hit              sprite overlaps a maze wall
//   L, R, U, D            last sprite move direction
//   my_end                sprite is in the exit zone
//   spr_on                sprite motion enable (PLAY/BOUNCE)
//   inc                   one-Clk pulse: reload sprite position (entering PLAY)
//   bnceL/R/U/D           bounce requests, held for the whole bounce
//   level[2:0]            current level index
//   state[2:0]            controller state code (state_t)
//   time_left[11:0]       frames remaining in the level
//
// There is no handshake: inputs are level signals sampled each Clk and all
// outputs are registered, changing one Clk after the edge that decided them.
// ---------------------------------------------------------------------------
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int NUM_LEVELS    = 4,
    parameter int BOUNCE_FRAMES = 8,
    parameter int DONE_FRAMES   = 60,
    parameter int LEVEL_TIME    = 1800
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic        wall_hit,
    input  logic        L,
    input  logic        R,
    input  logic        U,
    input  logic        D,
    input  logic        my_end,
    output logic        spr_on,
    output logic        inc,
    output logic        bnceL,
    output logic        bnceR,
    output logic        bnceU,
    output logic        bnceD,
    output logic [2:0]  level,
    output logic [2:0]  state,
    output logic [11:0] time_left
);

    logic   tick;
    logic   enter_q;
    logic   enter_press;

    state_t     state_q, state_n;
    logic [2:0] level_q, level_n;
    logic [7:0] bcnt_q,  bcnt_n;
    logic [7:0] dcnt_q,  dcnt_n;
    logic [3:0] bnce_q,  bnce_n;
    logic       inc_q,   inc_n;
    logic       spr_on_q, spr_on_n;
    logic       expire;

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Only a fresh Enter press counts, so a key held from the previous
    // screen cannot immediately start (or restart) a game.
    assign enter_press = (keycode == KEY_ENTER) && !enter_q;

`ifdef LEVEL_TIMER_EN
    logic [11:0] tl_q, tl_n;

    // Expires on the tick that takes the counter to zero.
    assign expire = tick && (tl_q <= 12'd1);

    always_comb begin
        tl_n = tl_q;
        if (inc_n)
            tl_n = 12'(LEVEL_TIME);
        else if (tick && (state_q == ST_PLAY || state_q == ST_BOUNCE) && tl_q != 12'd0)
            tl_n = tl_q - 12'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) tl_q <= '0;
        else       tl_q <= tl_n;
    end

    assign time_left = tl_q;
`else
    assign expire    = 1'b0;
    assign time_left = '0;
`endif

    always_comb begin
        state_n = state_q;
        level_n = level_q;
        bcnt_n  = bcnt_q;
        dcnt_n  = dcnt_q;
        bnce_n  = bnce_q;
        inc_n   = 1'b0;

        case (state_q)
            ST_TITLE: begin
                bnce_n = '0;
                if (enter_press) begin
                    state_n = ST_PLAY;
                    level_n = '0;
                    inc_n   = 1'b1;
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    if (my_end) begin
                        state_n = ST_LVL_DONE;
                        dcnt_n  = 8'(DONE_FRAMES);
                        bnce_n  = '0;
                    end else if (expire) begin
                        state_n = ST_OVER;
                        bnce_n  = '0;
                    end else if (wall_hit && (L || R || U || D)) begin
                        state_n = ST_BOUNCE;
                        bnce_n  = bounce_of(L, R, U, D);
                        bcnt_n  = 8'(BOUNCE_FRAMES);
                    end
                end
            end

            ST_BOUNCE: begin
                if (tick) begin
                    if (my_end) begin
                        state_n = ST_LVL_DONE;
                        dcnt_n  = 8'(DONE_FRAMES);
                        bnce_n  = '0;
                        bcnt_n  = '0;
                    end else if (expire) begin
                        state_n = ST_OVER;
                        bnce_n  = '0;
                        bcnt_n  = '0;
                    end else if (bcnt_q <= 8'd1) begin
                        state_n = ST_PLAY;
                        bnce_n  = '0;
                        bcnt_n  = '0;
                    end else begin
                        bcnt_n = bcnt_q - 8'd1;
                    end
                end
            end

            ST_LVL_DONE: begin
                bnce_n = '0;
                if (tick) begin
                    if (dcnt_q <= 8'd1) begin
                        dcnt_n = '0;
                        if (level_q == 3'(NUM_LEVELS - 1)) begin
                            state_n = ST_WIN;
                        end else begin
                            state_n = ST_PLAY;
                            level_n = level_q + 3'd1;
                            inc_n   = 1'b1;
                        end
                    end else begin
                        dcnt_n = dcnt_q - 8'd1;
                    end
                end
            end

            ST_WIN, ST_OVER: begin
                bnce_n = '0;
                if (enter_press)
                    state_n = ST_TITLE;
            end

            default: begin
                state_n = ST_TITLE;
                bnce_n  = '0;
                bcnt_n  = '0;
                dcnt_n  = '0;
            end
        endcase

        spr_on_n = (state_n == ST_PLAY) || (state_n == ST_BOUNCE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_TITLE;
            level_q  <= '0;
            bcnt_q   <= '0;
            dcnt_q   <= '0;
            bnce_q   <= '0;
            inc_q    <= 1'b0;
            spr_on_q <= 1'b0;
            enter_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            level_q  <= level_n;
            bcnt_q   <= bcnt_n;
            dcnt_q   <= dcnt_n;
            bnce_q   <= bnce_n;
            inc_q    <= inc_n;
            spr_on_q <= spr_on_n;
            enter_q  <= (keycode == KEY_ENTER);
        end
    end

    assign state  = state_q;
    assign level  = level_q;
    assign spr_on = spr_on_q;
    assign inc    = inc_q;
    assign bnceL  = bnce_q[DIR_L];
    assign bnceR  = bnce_q[DIR_R];
    assign bnceU  = bnce_q[DIR_U];
    assign bnceD  = bnce_q[DIR_D];

endmodule
